// File: rtl/debounce.sv
// ---------------------------------------------------------------------------
// debounce
//
// Cleans up a bouncing mechanical or otherwise asynchronous input. The raw
// input is first brought into the clk domain through a two-flop synchronizer,
// then a four-state FSM only lets the debounced output follow once the
// synchronized level has been steady for STABLE_CYCLES further cycles. A wait
// that is cut short by a bounce produces a one-cycle glitch pulse and bumps a
// saturating glitch counter.
//
// Parameters
//   STABLE_CYCLES  cycles a new synchronized level must persist after the FSM
//                  first sees it before out follows (1..65535)
//
// Ports
//   clk         in   1  clock, all state updates on the rising edge
//   rst_n       in   1  asynchronous active-low reset
//   in          in   1  raw input, no timing relation to clk
//   out         out  1  debounced level, straight from a flip-flop
//   glitch      out  1  one-cycle pulse: a pending level change was aborted
//   glitch_cnt  out  8  number of glitch pulses since reset, saturates at FF
// ---------------------------------------------------------------------------
module debounce #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  output logic       out,
  output logic       glitch,
  output logic [7:0] glitch_cnt
);

  // The counter must hold values up to STABLE_CYCLES-1; sizing it for
  // STABLE_CYCLES+1 values keeps STABLE_CYCLES=1 at a legal one-bit width.
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  logic          sync0;
  logic          sync1;
  logic          in_sync;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          out_q;
  logic          out_d;
  logic          glitch_q;
  logic          glitch_d;
  logic [7:0]    glitch_cnt_q;

  // Two-flop synchronizer. Only sync1 is ever looked at by the FSM, so the
  // possibly metastable first stage never fans out into the control logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= in;
      sync1 <= sync0;
    end
  end

  assign in_sync = sync1;

  // FSM state, wait counter and the registered outputs. out and glitch are
  // registered copies of the next-state decode so both leave the block
  // straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state logic. The counting states remember which level the output
  // currently shows (S_RISE still shows 0, S_FALL still shows 1), so an
  // aborted wait simply falls back to the idle state of the old level.
  // The counter stops at CNT_LAST: reaching it completes the transition
  // instead of incrementing, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;

    case (state_q)
      S_LOW: begin
        if (in_sync) begin
          state_d = S_RISE;
          cnt_d   = '0;
        end
      end

      S_RISE: begin
        if (!in_sync) begin
          state_d  = S_LOW;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HIGH: begin
        if (!in_sync) begin
          state_d = S_FALL;
          cnt_d   = '0;
        end
      end

      S_FALL: begin
        if (in_sync) begin
          state_d  = S_HIGH;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    out_d = (state_d == S_HIGH) || (state_d == S_FALL);
  end

  // Glitch counter advances on the same edge that raises glitch and sticks
  // at FF so a noisy input cannot make it look quiet again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_q <= 8'h00;
    end else if (glitch_d && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_q <= glitch_cnt_q + 8'h01;
    end
  end

  assign out        = out_q;
  assign glitch     = glitch_q;
  assign glitch_cnt = glitch_cnt_q;

`ifndef SYNTHESIS
  // The wait counter never runs past the last count of a transition.
  cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_LAST);

  // Aborting a wait never moves the output.
  no_toggle_on_glitch: assert property (@(posedge clk) disable iff (!rst_n)
    glitch_d |-> (out_d == out_q));
`endif

endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive clock cycles the synchronized input must hold a new level before the output follows; legal range 1..65535.
REQ-002 clk  input  1  clock, all state updated on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in  input  1  raw mechanical/asynchronous input, no timing relation to clk.
REQ-005 out  output  1  debounced level, driven directly by a flip-flop; intended to feed the edge-detection stage.
REQ-006 glitch  output  1  one-cycle pulse, a pending level change was aborted by a bounce.
REQ-007 glitch_cnt  output  8  count of glitch pulses since reset, saturating.

Function
REQ-008 in SHALL pass through a 2-flop synchronizer (sync0 <- in, sync1 <- sync0); only sync1 (in_sync) SHALL reach the FSM.
REQ-009 The FSM SHALL have four states: S_LOW (out=0, idle), S_RISE (out=0, counting), S_HIGH (out=1, idle), S_FALL (out=1, counting).
REQ-010 S_LOW: in_sync=1 -> S_RISE, cnt<=0; else stay.
REQ-011 S_RISE: in_sync=0 -> S_LOW with glitch=1 for that cycle; else if cnt==STABLE_CYCLES-1 -> S_HIGH with out<=1; else cnt<=cnt+1.
REQ-012 S_HIGH: in_sync=0 -> S_FALL, cnt<=0; else stay.
REQ-013 S_FALL: in_sync=1 -> S_HIGH with glitch=1 for that cycle; else if cnt==STABLE_CYCLES-1 -> S_LOW with out<=0; else cnt<=cnt+1.
REQ-014 cnt SHALL be ceil(log2(STABLE_CYCLES+1)) bits, never exceed STABLE_CYCLES-1, and SHALL NOT wrap.
REQ-015 Latency: if in is stable at a new level from sampling edge t0 onward, out SHALL change after edge t0+STABLE_CYCLES+2 and not earlier.
REQ-016 A level shorter than STABLE_CYCLES cycles at in_sync SHALL never reach out.
REQ-017 glitch SHALL be registered, high exactly one cycle per aborted wait, low in all other cycles.
REQ-018 glitch_cnt SHALL increment on the same edge glitch is asserted, hold at 8'hFF once reached, never wrap.
REQ-019 out SHALL change at most once per STABLE_CYCLES+1 cycles and SHALL never toggle in a cycle in which glitch is asserted.
REQ-020 STABLE_CYCLES=1: a single stable cycle in S_RISE/S_FALL SHALL complete the transition.

Reset
REQ-021 rst_n=0 SHALL immediately, without clk, force sync0=0, sync1=0, state=S_LOW, cnt=0, out=0, glitch=0, glitch_cnt=0.
REQ-022 Reset asserted mid-count (S_RISE/S_FALL) SHALL discard the pending transition; after release the FSM restarts from S_LOW.
REQ-023 After rst_n release with in held high, out SHALL rise STABLE_CYCLES+2 edges after the first sampling edge, as REQ-015.

Verification (STABLE_CYCLES=4)
REQ-024 Reset, then in 0->1 held: out=1 after edge t0+6, glitch never asserted, glitch_cnt=0.
REQ-025 in high for 3 sampling edges then low: out stays 0, glitch pulses once, glitch_cnt=1.
REQ-026 From out=1, in low for 4 cycles, high 2, low held: one glitch, out falls 6 edges after the final falling sample, glitch_cnt=1.
REQ-027 300 aborted bounces (in high 2 cycles, low 6 cycles, repeated): out stays 0, glitch_cnt=8'hFF at end.
REQ-028 rst_n pulsed low during S_RISE with cnt=2: out, glitch, glitch_cnt read 0 before next clk edge; with in still high, out rises 6 edges after release.
REQ-029 Random async in (bounce widths 1..10 cycles) against a reference model: out matches cycle-exactly, never 1-cycle pulses on out.
